// File: rtl/vector_result_collector_if.sv
// Bus bundle between the ALU lane array, the vector result collector and the register-file write port.
interface vector_result_collector_if #(
    parameter int ELEMS = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    localparam int VW = $clog2(ELEMS + 1);

    logic                   start;
    logic [AW-1:0]          dest_addr;
    logic [VW-1:0]          vlen;
    logic [3:0]             lane_valid;
    logic [WIDTH-1:0]       result0;
    logic [WIDTH-1:0]       result1;
    logic [WIDTH-1:0]       result2;
    logic [WIDTH-1:0]       result3;
    logic                   busy;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [ELEMS*WIDTH-1:0] wr_data;
    logic [ELEMS-1:0]       wr_mask;
    logic                   done;
    logic                   overrun;

    modport master (
        output start, dest_addr, vlen, lane_valid, result0, result1, result2, result3,
        input  busy, wr_en, wr_addr, wr_data, wr_mask, done, overrun
    );

    modport slave (
        input  start, dest_addr, vlen, lane_valid, result0, result1, result2, result3,
        output busy, wr_en, wr_addr, wr_data, wr_mask, done, overrun
    );
endinterface

// File: rtl/vector_result_collector.sv
// Collects per-lane ALU results of one vector, group by group, then issues one masked register-file write.
// Latency: wr_en one cycle after the last element is captured; lanes are never stalled, duplicates raise overrun.
module vector_result_collector #(
    parameter int ELEMS = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    vector_result_collector_if.slave   bus
);
    localparam int VW = $clog2(ELEMS + 1);
    localparam int GW = $clog2(ELEMS / 4 + 1);
    localparam int CW = VW + 2;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [GW-1:0]     r_g;
    logic [3:0]        r_got;
    logic [VW-1:0]     r_vlen;
    logic [AW-1:0]     r_addr;
    logic [ELEMS-1:0]  r_mask;
    logic              r_ovr;
    logic              r_err_pend;

    logic [WIDTH-1:0]  w_res [4];
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_in_col;
    logic [CW-1:0]     w_base;
    logic [3:0]        w_act;
    logic [3:0]        w_cap;
    logic [3:0]        w_dup;
    logic              w_grp_done;
    logic              w_last;
    logic [ELEMS-1:0]  w_mask_nxt;

    assign w_res[0] = bus.result0;
    assign w_res[1] = bus.result1;
    assign w_res[2] = bus.result2;
    assign w_res[3] = bus.result3;

    assign w_start_ok  = bus.start && (r_state == S_IDLE) && (bus.vlen != '0)
                         && (bus.vlen <= VW'(ELEMS));
    assign w_start_bad = bus.start && (r_state == S_IDLE) && !w_start_ok;
    assign w_in_col    = (r_state == S_COLLECT);

    // A lane is active only while its element index falls below the vector length.
    always_comb begin
        w_act  = '0;
        w_base = CW'(r_g) << 2;
        for (int i = 0; i < 4; i++) begin
            w_act[i] = (w_base + CW'(i)) < CW'(r_vlen);
        end
        w_mask_nxt = '0;
        for (int k = 0; k < ELEMS; k++) begin
            w_mask_nxt[k] = CW'(k) < CW'(bus.vlen);
        end
    end

    assign w_cap      = w_in_col ? (bus.lane_valid & w_act & ~r_got) : 4'b0000;
    assign w_dup      = w_in_col ? (bus.lane_valid & w_act &  r_got) : 4'b0000;
    assign w_grp_done = w_in_col && (((r_got | w_cap) & w_act) == w_act);
    assign w_last     = (w_base + CW'(4)) >= CW'(r_vlen);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start_ok) w_state_nxt = S_COLLECT;
            S_COLLECT: if (w_grp_done && w_last) w_state_nxt = S_WRITE;
            S_WRITE:   w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (r_state != S_IDLE);
        bus.wr_en = (r_state == S_WRITE);
        bus.done  = (r_state == S_WRITE) || r_err_pend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g        <= '0;
            r_got      <= '0;
            r_vlen     <= '0;
            r_addr     <= '0;
            r_mask     <= '0;
            r_ovr      <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_err_pend <= w_start_bad;
            if (w_start_ok) begin
                r_g    <= '0;
                r_got  <= '0;
                r_vlen <= bus.vlen;
                r_addr <= bus.dest_addr;
                r_mask <= w_mask_nxt;
                r_ovr  <= 1'b0;
            end else begin
                if (w_start_bad || (w_dup != 4'b0000)) r_ovr <= 1'b1;
                if (w_grp_done) begin
                    r_got <= '0;
                    if (!w_last) r_g <= r_g + GW'(1);
                end else if (w_in_col) begin
                    r_got <= r_got | w_cap;
                end
            end
        end
    end

    // Element k belongs to group k/4 and is fed by lane k%4.
    for (genvar k = 0; k < ELEMS; k++) begin : g_elem
        logic [WIDTH-1:0] r_elem;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                       r_elem <= '0;
            else if (w_start_ok)                              r_elem <= '0;
            else if ((r_g == GW'(k / 4)) && w_cap[k % 4])     r_elem <= w_res[k % 4];
        end
        assign bus.wr_data[k*WIDTH +: WIDTH] = r_elem;
    end

    assign bus.wr_addr = r_addr;
    assign bus.wr_mask = r_mask;
    assign bus.overrun = r_ovr;
endmodule

// File: tb/tb_vector_result_collector.sv
module tb_vector_result_collector;
    localparam int ELEMS = 16;
    localparam int WIDTH = 32;
    localparam int AW    = 4;
    localparam int DW    = ELEMS * WIDTH;

    typedef struct {
        logic             wr;
        logic             ovr;
        logic [AW-1:0]    addr;
        logic [ELEMS-1:0] mask;
        logic [DW-1:0]    data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    vector_result_collector_if #(.ELEMS(ELEMS), .WIDTH(WIDTH), .AW(AW)) ifc ();

    vector_result_collector #(.ELEMS(ELEMS), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done/wr_en cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && (ifc.done || ifc.wr_en)) begin
            if (q.size() == 0) begin
                chk("spurious_done", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done",    ifc.done,    1'b1);
                chk("wr_en",   ifc.wr_en,   e.wr);
                chk("overrun", ifc.overrun, e.ovr);
                if (e.wr) begin
                    chk("wr_addr", ifc.wr_addr, e.addr);
                    chk("wr_mask", ifc.wr_mask, e.mask);
                    chk("wr_data", ifc.wr_data, e.data);
                end
            end
        end
    end

    task automatic push(input logic wr, input logic ovr, input logic [AW-1:0] addr,
                        input logic [ELEMS-1:0] mask, input logic [DW-1:0] data);
        exp_t e;
        e.wr = wr; e.ovr = ovr; e.addr = addr; e.mask = mask; e.data = data;
        q.push_back(e);
    endtask

    task automatic start_vec(input logic [AW-1:0] addr, input int vl);
        ifc.start     = 1'b1;
        ifc.dest_addr = addr;
        ifc.vlen      = 5'(vl);
        @(posedge clk); #1;
        ifc.start     = 1'b0;
    endtask

    task automatic cyc(input logic [3:0] lv, input int a, input int b, input int c, input int d);
        ifc.lane_valid = lv;
        ifc.result0 = a; ifc.result1 = b; ifc.result2 = c; ifc.result3 = d;
        @(posedge clk); #1;
        ifc.lane_valid = 4'b0000;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && (ifc.busy || ifc.done); i++) begin
            @(posedge clk); #1;
        end
        chk("idle_timeout", ifc.busy | ifc.done, 1'b0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"},    ifc.busy,    1'b0);
        chk({nm, "_wr_en"},   ifc.wr_en,   1'b0);
        chk({nm, "_done"},    ifc.done,    1'b0);
        chk({nm, "_overrun"}, ifc.overrun, 1'b0);
        chk({nm, "_wr_addr"}, ifc.wr_addr, '0);
        chk({nm, "_wr_mask"}, ifc.wr_mask, '0);
        chk({nm, "_wr_data"}, ifc.wr_data, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        rst_n = 1'b0;
        ifc.start = 1'b0; ifc.dest_addr = '0; ifc.vlen = '0; ifc.lane_valid = '0;
        ifc.result0 = '0; ifc.result1 = '0; ifc.result2 = '0; ifc.result3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // vlen=4, all lanes in the first cycle
        d = '0;
        for (int k = 0; k < 4; k++) d[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
        push(1'b1, 1'b0, 4'd3, 16'h000F, d);
        start_vec(4'd3, 4);
        chk("busy_after_start", ifc.busy, 1'b1);
        cyc(4'b1111, 1, 2, 3, 4);
        chk("wr_en_latency", ifc.wr_en, 1'b1);
        wait_idle();

        // vlen=16, lane 0 first, lanes 1-3 two cycles later, per group
        d = '0;
        for (int k = 0; k < 16; k++) d[k*WIDTH +: WIDTH] = WIDTH'(100 + k);
        push(1'b1, 1'b0, 4'd10, 16'hFFFF, d);
        start_vec(4'd10, 16);
        for (int g = 0; g < 4; g++) begin
            cyc(4'b0001, 100 + 4*g, 0, 0, 0);
            cyc(4'b0000, 0, 0, 0, 0);
            cyc(4'b1110, 0, 101 + 4*g, 102 + 4*g, 103 + 4*g);
        end
        wait_idle();

        // vlen=6, lanes 2/3 of group 1 are inactive
        d = '0;
        for (int k = 0; k < 6; k++) d[k*WIDTH +: WIDTH] = WIDTH'(10 + k);
        push(1'b1, 1'b0, 4'd5, 16'h003F, d);
        start_vec(4'd5, 6);
        cyc(4'b1111, 10, 11, 12, 13);
        cyc(4'b1111, 14, 15, 99, 98);
        wait_idle();
        chk("vlen6_no_overrun", ifc.overrun, 1'b0);

        // duplicate strobe on lane 2
        d = '0;
        d[0*WIDTH +: WIDTH] = 20; d[1*WIDTH +: WIDTH] = 21;
        d[2*WIDTH +: WIDTH] = 7;  d[3*WIDTH +: WIDTH] = 23;
        push(1'b1, 1'b1, 4'd7, 16'h000F, d);
        start_vec(4'd7, 4);
        cyc(4'b0100, 0, 0, 7, 0);
        cyc(4'b0100, 0, 0, 9, 0);
        chk("overrun_set", ifc.overrun, 1'b1);
        cyc(4'b1011, 20, 21, 0, 23);
        wait_idle();
        chk("overrun_sticky", ifc.overrun, 1'b1);

        // reset after two groups aborts the vector
        start_vec(4'd9, 16);
        chk("overrun_cleared", ifc.overrun, 1'b0);
        cyc(4'b1111, 30, 31, 32, 33);
        cyc(4'b1111, 34, 35, 36, 37);
        rst_n = 1'b0;
        #2;
        chk_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_idle", ifc.busy | ifc.wr_en | ifc.done, 1'b0);

        d = '0;
        for (int k = 0; k < 8; k++) d[k*WIDTH +: WIDTH] = WIDTH'(50 + k);
        push(1'b1, 1'b0, 4'd2, 16'h00FF, d);
        start_vec(4'd2, 8);
        cyc(4'b1111, 50, 51, 52, 53);
        cyc(4'b1111, 54, 55, 56, 57);
        wait_idle();

        // illegal lengths: vlen > ELEMS and vlen = 0
        push(1'b0, 1'b1, '0, '0, '0);
        start_vec(4'd4, 17);
        chk("vlen17_busy", ifc.busy, 1'b0);
        chk("vlen17_overrun", ifc.overrun, 1'b1);
        wait_idle();
        chk("vlen17_mask_kept", ifc.wr_mask, 16'h00FF);

        d = '0;
        for (int k = 0; k < 4; k++) d[k*WIDTH +: WIDTH] = WIDTH'(60 + k);
        push(1'b1, 1'b0, 4'd1, 16'h000F, d);
        start_vec(4'd1, 4);
        cyc(4'b1111, 60, 61, 62, 63);
        wait_idle();

        push(1'b0, 1'b1, '0, '0, '0);
        start_vec(4'd6, 0);
        chk("vlen0_busy", ifc.busy, 1'b0);
        chk("vlen0_overrun", ifc.overrun, 1'b1);
        wait_idle();
        chk("vlen0_addr_kept", ifc.wr_addr, 4'd1);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
